// File: rtl/ramio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ramio_pkg
// Description : Shared encodings and lane helpers for the rv32i ramio port.
//               The core and ramio_bridge import the same read/write type
//               constants so both sides agree on the command encoding.
//               Contents:
//                 - read_type / write_type / access-size constants
//                 - ramio_state_e : bridge FSM states
//                 - ramio_cmd_t   : {address, read_type, write_type} command
//                 - ramio_strobe, ramio_misaligned, ramio_sign_pos helpers
// Revision    : 1.0 - initial release
// ============================================================================
package ramio_pkg;

    // Access sizes, shared by write_type and read_type[1:0].
    localparam logic [1:0] RAMIO_SIZE_NONE = 2'b00;
    localparam logic [1:0] RAMIO_SIZE_BYTE = 2'b01;
    localparam logic [1:0] RAMIO_SIZE_HALF = 2'b10;
    localparam logic [1:0] RAMIO_SIZE_WORD = 2'b11;

    // write_type encodings.
    localparam logic [1:0] RAMIO_WRITE_NONE = 2'b00;
    localparam logic [1:0] RAMIO_WRITE_SB   = 2'b01;
    localparam logic [1:0] RAMIO_WRITE_SH   = 2'b10;
    localparam logic [1:0] RAMIO_WRITE_SW   = 2'b11;

    // read_type encodings: bit 2 requests sign extension, [1:0] is the size.
    localparam logic [2:0] RAMIO_READ_NONE = 3'b000;
    localparam logic [2:0] RAMIO_READ_LBU  = 3'b001;
    localparam logic [2:0] RAMIO_READ_LHU  = 3'b010;
    localparam logic [2:0] RAMIO_READ_LB   = 3'b101;
    localparam logic [2:0] RAMIO_READ_LH   = 3'b110;
    localparam logic [2:0] RAMIO_READ_LW   = 3'b111;
    localparam int         RAMIO_READ_SIGN_BIT = 2;

    typedef enum logic [1:0] {
        RAMIO_ST_IDLE       = 2'd0,
        RAMIO_ST_READ_WAIT  = 2'd1,
        RAMIO_ST_WRITE_WAIT = 2'd2,
        RAMIO_ST_DRAIN      = 2'd3
    } ramio_state_e;

    typedef struct packed {
        logic [31:0] address;
        logic [2:0]  read_type;
        logic [1:0]  write_type;
    } ramio_cmd_t;

    // Byte enables for an access of the given size at byte offset a.
    // Half ignores a[0] and word ignores a[1:0] (truncating behaviour).
    function automatic logic [3:0] ramio_strobe(input logic [1:0] size,
                                                input logic [1:0] a);
        logic [3:0] s;
        case (size)
            RAMIO_SIZE_BYTE: s = 4'b0001 << a;
            RAMIO_SIZE_HALF: s = a[1] ? 4'b1100 : 4'b0011;
            RAMIO_SIZE_WORD: s = 4'b1111;
            default:         s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic ramio_misaligned(input logic [1:0] size,
                                              input logic [1:0] a);
        logic m;
        case (size)
            RAMIO_SIZE_HALF: m = a[0];
            RAMIO_SIZE_WORD: m = (a != 2'b00);
            default:         m = 1'b0;
        endcase
        return m;
    endfunction

    // Bit position of the sign bit of a right-aligned value of this size.
    function automatic logic [4:0] ramio_sign_pos(input logic [1:0] size);
        logic [4:0] p;
        case (size)
            RAMIO_SIZE_BYTE: p = 5'd7;
            RAMIO_SIZE_HALF: p = 5'd15;
            default:         p = 5'd31;
        endcase
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ramio_bridge_byte_lane.sv
`default_nettype none
// ============================================================================
// Module      : ramio_byte_lane
// Description : Purely combinational lane logic for ramio_bridge.
//               Write side: byte strobes and replicated write data.
//               Read side : byte/half selection from the memory word plus
//                           zero or sign extension.
// Ports       : write_size/write_offset/write_data -> write_strobe, write_lanes
//               read_type/read_offset/read_word    -> read_data
// Revision    : 1.0 - initial release
// ============================================================================
module ramio_byte_lane
    import ramio_pkg::*;
(
    input  logic [1:0]  write_size,
    input  logic [1:0]  write_offset,
    input  logic [31:0] write_data,
    output logic [3:0]  write_strobe,
    output logic [31:0] write_lanes,
    input  logic [2:0]  read_type,
    input  logic [1:0]  read_offset,
    input  logic [31:0] read_word,
    output logic [31:0] read_data
);

    logic [1:0]  read_size;
    logic [4:0]  shift_amount;
    logic [4:0]  sign_pos;
    logic [31:0] shifted;
    logic        sign;

    // Replicating the data across all lanes lets the strobes alone pick
    // the destination bytes.
    always_comb begin
        write_strobe = ramio_strobe(write_size, write_offset);
        case (write_size)
            RAMIO_SIZE_BYTE: write_lanes = {4{write_data[7:0]}};
            RAMIO_SIZE_HALF: write_lanes = {2{write_data[15:0]}};
            default:         write_lanes = write_data;
        endcase
    end

    always_comb begin
        read_size = read_type[1:0];
        case (read_size)
            RAMIO_SIZE_BYTE: shift_amount = {read_offset, 3'b000};
            RAMIO_SIZE_HALF: shift_amount = {read_offset[1], 4'b0000};
            default:         shift_amount = 5'd0;
        endcase
        shifted  = read_word >> shift_amount;
        sign_pos = ramio_sign_pos(read_size);
        sign     = read_type[RAMIO_READ_SIGN_BIT] & shifted[sign_pos];
        case (read_size)
            RAMIO_SIZE_BYTE: read_data = {{24{sign}}, shifted[7:0]};
            RAMIO_SIZE_HALF: read_data = {{16{sign}}, shifted[15:0]};
            default:         read_data = shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ramio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ramio_bridge
// Description : Converts the rv32i core's byte-addressed byte/half/word
//               accesses into word accesses with byte strobes for the
//               cache/PSRAM controller, and produces the busy/data_out_ready
//               handshake for the core.
// Ports       : core side   - enable, read_type, write_type, address, data_in,
//                             data_out, data_out_ready, busy, error
//               memory side - mem_enable, mem_address, mem_write_strobe,
//                             mem_data_in, mem_data_out, mem_data_out_ready,
//                             mem_busy
// Options     : RAMIO_ALIGN_CHECK_EN - misaligned half/word accesses skip
//               memory, read 0, complete in one cycle and set sticky error.
//               Undefined: error is 0 and misaligned accesses are truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module ramio_bridge
    import ramio_pkg::*;
#(
    parameter int MemAddressWidth = 21
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [2:0]                 read_type,
    input  logic [1:0]                 write_type,
    input  logic [31:0]                address,
    input  logic [31:0]                data_in,
    output logic [31:0]                data_out,
    output logic                       data_out_ready,
    output logic                       busy,
    output logic                       mem_enable,
    output logic [MemAddressWidth-1:0] mem_address,
    output logic [3:0]                 mem_write_strobe,
    output logic [31:0]                mem_data_in,
    input  logic [31:0]                mem_data_out,
    input  logic                       mem_data_out_ready,
    input  logic                       mem_busy,
    output logic                       error
);

    ramio_cmd_t   command;
    ramio_state_e state, state_d;

    // done_valid plays the role of a registered enable: it is cleared
    // whenever enable is low, so re-asserting enable with an identical
    // command is treated as a fresh request.
    logic                       done_valid, done_valid_d;
    ramio_cmd_t                 done_command, done_command_d;
    ramio_cmd_t                 pending_command, pending_command_d;
    logic                       ready_q, ready_d;
    logic [31:0]                data_out_d;
    logic                       mem_enable_d;
    logic [MemAddressWidth-1:0] mem_address_d;
    logic [3:0]                 mem_write_strobe_d;
    logic [31:0]                mem_data_in_d;

    logic        cmd_match;
    logic        new_request;
    logic        is_write;
    logic        is_read;
    logic [1:0]  access_size;
    logic        misaligned;
    logic        pending_match;
    logic [3:0]  lane_strobe;
    logic [31:0] lane_write_data;
    logic [31:0] lane_read_data;

    assign command       = '{address: address, read_type: read_type, write_type: write_type};
    assign cmd_match     = done_valid && (command == done_command);
    assign new_request   = enable && !cmd_match;
    // Writes take priority when both types are nonzero.
    assign is_write      = (write_type != RAMIO_WRITE_NONE);
    assign is_read       = !is_write && (read_type[1:0] != RAMIO_SIZE_NONE);
    assign access_size   = is_write ? write_type : read_type[1:0];
    assign pending_match = enable && (command == pending_command);

`ifdef RAMIO_ALIGN_CHECK_EN
    logic error_q, error_d;
    assign misaligned = ramio_misaligned(access_size, address[1:0]);
    assign error      = error_q;
`else
    assign misaligned = 1'b0;
    assign error      = 1'b0;
`endif

    // Both outputs are gated by rst_n so they fall with reset, without
    // waiting for a clock edge.
    assign busy           = rst_n && enable && !((state == RAMIO_ST_IDLE) && cmd_match);
    assign data_out_ready = rst_n && enable && ready_q && cmd_match;

    ramio_byte_lane u_byte_lane (
        .write_size   (write_type),
        .write_offset (address[1:0]),
        .write_data   (data_in),
        .write_strobe (lane_strobe),
        .write_lanes  (lane_write_data),
        .read_type    (pending_command.read_type),
        .read_offset  (pending_command.address[1:0]),
        .read_word    (mem_data_out),
        .read_data    (lane_read_data)
    );

    always_comb begin
        state_d            = state;
        done_valid_d       = done_valid;
        done_command_d     = done_command;
        pending_command_d  = pending_command;
        ready_d            = ready_q;
        data_out_d         = data_out;
        mem_enable_d       = mem_enable;
        mem_address_d      = mem_address;
        mem_write_strobe_d = mem_write_strobe;
        mem_data_in_d      = mem_data_in;
`ifdef RAMIO_ALIGN_CHECK_EN
        error_d            = error_q;
`endif

        case (state)
            RAMIO_ST_IDLE: begin
                if (new_request) begin
                    if ((!is_write && !is_read) || misaligned) begin
                        // Nothing to send to memory: finish in this cycle.
                        done_command_d = command;
                        done_valid_d   = 1'b1;
                        ready_d        = is_read;
                        if (is_read) begin
                            data_out_d = 32'd0;
                        end
`ifdef RAMIO_ALIGN_CHECK_EN
                        error_d = error_q | misaligned;
`endif
                    end else if (!mem_busy) begin
                        mem_enable_d      = 1'b1;
                        mem_address_d     = address[MemAddressWidth+1:2];
                        pending_command_d = command;
                        done_valid_d      = 1'b0;
                        ready_d           = 1'b0;
                        if (is_write) begin
                            mem_write_strobe_d = lane_strobe;
                            mem_data_in_d      = lane_write_data;
                            state_d            = RAMIO_ST_WRITE_WAIT;
                        end else begin
                            mem_write_strobe_d = 4'b0000;
                            state_d            = RAMIO_ST_READ_WAIT;
                        end
                    end
                end
            end

            RAMIO_ST_READ_WAIT: begin
                if (mem_data_out_ready) begin
                    mem_enable_d = 1'b0;
                    state_d      = RAMIO_ST_IDLE;
                    // A result for a command the core has since abandoned
                    // is dropped; the new command is picked up from Idle.
                    if (pending_match) begin
                        data_out_d     = lane_read_data;
                        ready_d        = 1'b1;
                        done_command_d = pending_command;
                        done_valid_d   = 1'b1;
                    end
                end else if (!pending_match) begin
                    state_d = RAMIO_ST_DRAIN;
                end
            end

            RAMIO_ST_WRITE_WAIT: begin
                if (!mem_busy) begin
                    mem_enable_d       = 1'b0;
                    mem_write_strobe_d = 4'b0000;
                    done_command_d     = pending_command;
                    done_valid_d       = 1'b1;
                    ready_d            = 1'b0;
                    state_d            = RAMIO_ST_IDLE;
                end
            end

            RAMIO_ST_DRAIN: begin
                if (mem_data_out_ready) begin
                    mem_enable_d = 1'b0;
                    state_d      = RAMIO_ST_IDLE;
                end
            end

            default: begin
                state_d = RAMIO_ST_IDLE;
            end
        endcase

        done_valid_d = done_valid_d & enable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= RAMIO_ST_IDLE;
            done_valid       <= 1'b0;
            done_command     <= '0;
            pending_command  <= '0;
            ready_q          <= 1'b0;
            data_out         <= 32'd0;
            mem_enable       <= 1'b0;
            mem_address      <= '0;
            mem_write_strobe <= 4'b0000;
            mem_data_in      <= 32'd0;
        end else begin
            state            <= state_d;
            done_valid       <= done_valid_d;
            done_command     <= done_command_d;
            pending_command  <= pending_command_d;
            ready_q          <= ready_d;
            data_out         <= data_out_d;
            mem_enable       <= mem_enable_d;
            mem_address      <= mem_address_d;
            mem_write_strobe <= mem_write_strobe_d;
            mem_data_in      <= mem_data_in_d;
        end
    end

`ifdef RAMIO_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ramio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ramio_bridge
// Description : Self-checking bench for ramio_bridge. A small word memory
//               model answers reads after a programmable delay and commits
//               strobed writes; directed vectors and hand-written sequences
//               compare DUT outputs against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ramio_bridge;
    import ramio_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [2:0]  read_type;
    logic [1:0]  write_type;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        busy;
    logic        mem_enable;
    logic [20:0] mem_address;
    logic [3:0]  mem_write_strobe;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out = 32'd0;
    logic        mem_data_out_ready = 1'b0;
    logic        mem_busy;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ramio_bridge #(.MemAddressWidth(21)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .enable             (enable),
        .read_type          (read_type),
        .write_type         (write_type),
        .address            (address),
        .data_in            (data_in),
        .data_out           (data_out),
        .data_out_ready     (data_out_ready),
        .busy               (busy),
        .mem_enable         (mem_enable),
        .mem_address        (mem_address),
        .mem_write_strobe   (mem_write_strobe),
        .mem_data_in        (mem_data_in),
        .mem_data_out       (mem_data_out),
        .mem_data_out_ready (mem_data_out_ready),
        .mem_busy           (mem_busy),
        .error              (error)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem_arr [0:15];
    int          rd_delay = 0;
    int          m_cnt = 0;
    logic [3:0]  m_idx = 4'd0;

    always @(posedge clk) begin
        if (mem_data_out_ready) begin
            mem_data_out_ready <= 1'b0;
        end else if (m_cnt > 0) begin
            if (m_cnt == 1) begin
                mem_data_out_ready <= 1'b1;
                mem_data_out       <= mem_arr[m_idx];
            end
            m_cnt <= m_cnt - 1;
        end else if (mem_enable && mem_write_strobe == 4'b0000) begin
            m_idx <= mem_address[3:0];
            if (rd_delay == 0) begin
                mem_data_out_ready <= 1'b1;
                mem_data_out       <= mem_arr[mem_address[3:0]];
            end else begin
                m_cnt <= rd_delay;
            end
        end
        if (mem_enable && mem_write_strobe != 4'b0000 && !mem_busy) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_write_strobe[b]) begin
                    mem_arr[mem_address[3:0]][8*b +: 8] = mem_data_in[8*b +: 8];
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_not_busy(input int bound);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (busy && cyc < bound);
    endtask

    task automatic wait_ready(input int bound);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!data_out_ready && cyc < bound);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  rt;
        logic [1:0]  wt;
        logic [31:0] wdata;
        logic [31:0] memword;
        logic [31:0] exp_data;
        logic [3:0]  exp_strobe;
        logic [31:0] exp_mdata;
    } vec_t;

    vec_t vecs [0:12];

    task automatic run_vec(input vec_t v, input int idx);
        int          cyc;
        logic        seen;
        logic [3:0]  st;
        logic [31:0] md;
        logic [20:0] ma;
        @(negedge clk);
        mem_arr[v.addr[5:2]] = v.memword;
        address    = v.addr;
        read_type  = v.rt;
        write_type = v.wt;
        data_in    = v.wdata;
        enable     = 1'b1;
        seen = 1'b0;
        st   = 4'd0;
        md   = 32'd0;
        ma   = 21'd0;
        cyc  = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (mem_enable && !seen) begin
                seen = 1'b1;
                st   = mem_write_strobe;
                md   = mem_data_in;
                ma   = mem_address;
            end
        end while (busy && cyc < 20);
        check($sformatf("vec%0d busy done", idx), {31'd0, busy}, 32'd0);
        check($sformatf("vec%0d mem_address", idx), {11'd0, ma}, {11'd0, v.addr[22:2]});
        if (v.wt != RAMIO_WRITE_NONE) begin
            check($sformatf("vec%0d strobe", idx), {28'd0, st}, {28'd0, v.exp_strobe});
            check($sformatf("vec%0d mem_data_in", idx), md, v.exp_mdata);
        end else begin
            check($sformatf("vec%0d data_out", idx), data_out, v.exp_data);
            check($sformatf("vec%0d data_out_ready", idx), {31'd0, data_out_ready}, 32'd1);
        end
        enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_stale;
        for (int i = 0; i < 16; i++) mem_arr[i] = 32'd0;
        //          addr          rt              wt               wdata         memword       exp_data      strobe   mdata
        vecs[0]  = '{32'h0000_0102, RAMIO_READ_LB,   RAMIO_WRITE_NONE, 32'h0,        32'h8180_7F01, 32'hFFFF_FF80, 4'b0000, 32'h0};
        vecs[1]  = '{32'h0000_0102, RAMIO_READ_LBU,  RAMIO_WRITE_NONE, 32'h0,        32'h8180_7F01, 32'h0000_0080, 4'b0000, 32'h0};
        vecs[2]  = '{32'h0000_0101, RAMIO_READ_LB,   RAMIO_WRITE_NONE, 32'h0,        32'h8180_7F01, 32'h0000_007F, 4'b0000, 32'h0};
        vecs[3]  = '{32'h0000_0106, RAMIO_READ_LH,   RAMIO_WRITE_NONE, 32'h0,        32'h8001_1234, 32'hFFFF_8001, 4'b0000, 32'h0};
        vecs[4]  = '{32'h0000_0104, RAMIO_READ_LHU,  RAMIO_WRITE_NONE, 32'h0,        32'h8001_1234, 32'h0000_1234, 4'b0000, 32'h0};
        vecs[5]  = '{32'h0000_0108, RAMIO_READ_LW,   RAMIO_WRITE_NONE, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0000, 32'h0};
        vecs[6]  = '{32'h0000_0103, RAMIO_READ_LBU,  RAMIO_WRITE_NONE, 32'h0,        32'hC3B2_A190, 32'h0000_00C3, 4'b0000, 32'h0};
        vecs[7]  = '{32'h0000_010D, RAMIO_READ_NONE, RAMIO_WRITE_SB,   32'h0000_00A5, 32'h0,        32'h0,         4'b0010, 32'hA5A5_A5A5};
        vecs[8]  = '{32'h0000_0106, RAMIO_READ_NONE, RAMIO_WRITE_SH,   32'h1234_ABCD, 32'h0,        32'h0,         4'b1100, 32'hABCD_ABCD};
        vecs[9]  = '{32'h0000_010C, RAMIO_READ_NONE, RAMIO_WRITE_SW,   32'hCAFE_F00D, 32'h0,        32'h0,         4'b1111, 32'hCAFE_F00D};
        vecs[10] = '{32'h0000_0100, RAMIO_READ_NONE, RAMIO_WRITE_SH,   32'h5555_1234, 32'h0,        32'h0,         4'b0011, 32'h1234_1234};
        vecs[11] = '{32'h0000_0103, RAMIO_READ_NONE, RAMIO_WRITE_SB,   32'h0000_0077, 32'h0,        32'h0,         4'b1000, 32'h7777_7777};
        vecs[12] = '{32'h0000_0110, RAMIO_READ_LB,   RAMIO_WRITE_SW,   32'h0F0E_0D0C, 32'h0,        32'h0,         4'b1111, 32'h0F0E_0D0C};

        rst_n      = 1'b0;
        enable     = 1'b0;
        read_type  = 3'd0;
        write_type = 2'd0;
        address    = 32'd0;
        data_in    = 32'd0;
        mem_busy   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values.
        check("rst data_out", data_out, 32'd0);
        check("rst data_out_ready", {31'd0, data_out_ready}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst mem_enable", {31'd0, mem_enable}, 32'd0);
        check("rst mem_write_strobe", {28'd0, mem_write_strobe}, 32'd0);
        check("rst mem_address", {11'd0, mem_address}, 32'd0);
        check("rst mem_data_in", mem_data_in, 32'd0);
        check("rst error", {31'd0, error}, 32'd0);

        // LB cycle-exact latency with zero-wait memory.
        mem_arr[0] = 32'h8180_7F01;
        address    = 32'h0000_0102;
        read_type  = RAMIO_READ_LB;
        write_type = RAMIO_WRITE_NONE;
        enable     = 1'b1;
        #1 check("lb busy cycle0", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("lb mem_enable cycle1", {31'd0, mem_enable}, 32'd1);
        check("lb ready cycle1", {31'd0, data_out_ready}, 32'd0);
        @(negedge clk);
        check("lb ready cycle2", {31'd0, data_out_ready}, 32'd0);
        @(negedge clk);
        check("lb ready cycle3", {31'd0, data_out_ready}, 32'd1);
        check("lb data cycle3", data_out, 32'hFFFF_FF80);
        check("lb busy cycle3", {31'd0, busy}, 32'd0);
        enable = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // SH with memory busy for a few cycles.
        @(negedge clk);
        address    = 32'h0000_0106;
        write_type = RAMIO_WRITE_SH;
        read_type  = RAMIO_READ_NONE;
        data_in    = 32'h1234_ABCD;
        enable     = 1'b1;
        @(negedge clk);
        mem_busy = 1'b1;
        check("sh strobe", {28'd0, mem_write_strobe}, 32'h0000_000C);
        check("sh data", mem_data_in, 32'hABCD_ABCD);
        repeat (3) begin
            @(negedge clk);
            check("sh busy while mem_busy", {31'd0, busy}, 32'd1);
        end
        mem_busy = 1'b0;
        #1 check("sh busy as mem_busy falls", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("sh busy after", {31'd0, busy}, 32'd0);
        check("sh mem_enable after", {31'd0, mem_enable}, 32'd0);
        enable = 1'b0;

        // SW to A, then switch to LW of B with enable held high.
        mem_arr[1] = 32'h0BAD_CAFE;
        @(negedge clk);
        address    = 32'h0000_0200;
        write_type = RAMIO_WRITE_SW;
        read_type  = RAMIO_READ_NONE;
        data_in    = 32'h1122_3344;
        enable     = 1'b1;
        wait_not_busy(20);
        check("sw done", {31'd0, busy}, 32'd0);
        check("sw committed", mem_arr[0], 32'h1122_3344);
        address    = 32'h0000_0304;
        write_type = RAMIO_WRITE_NONE;
        read_type  = RAMIO_READ_LW;
        #1 check("switch busy immediate", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("switch mem_enable", {31'd0, mem_enable}, 32'd1);
        check("switch mem_address", {11'd0, mem_address}, 32'h0000_00C1);
        check("switch strobe", {28'd0, mem_write_strobe}, 32'd0);
        wait_ready(20);
        check("switch ready", {31'd0, data_out_ready}, 32'd1);
        check("switch data", data_out, 32'h0BAD_CAFE);
        enable = 1'b0;

        // Command change while the read is outstanding.
        rd_delay   = 5;
        mem_arr[2] = 32'hAAAA_0001;
        mem_arr[3] = 32'hBBBB_0002;
        @(negedge clk);
        address    = 32'h0000_0308;
        read_type  = RAMIO_READ_LW;
        write_type = RAMIO_WRITE_NONE;
        enable     = 1'b1;
        @(negedge clk);
        check("drain first issue", {31'd0, mem_enable}, 32'd1);
        @(negedge clk);
        address = 32'h0000_030C;
        seen_stale = 1'b0;
        for (int c = 0; c < 60 && !data_out_ready; c++) begin
            @(negedge clk);
            if (data_out == 32'hAAAA_0001) seen_stale = 1'b1;
        end
        check("drain ready", {31'd0, data_out_ready}, 32'd1);
        check("drain data", data_out, 32'hBBBB_0002);
        check("drain mem_address", {11'd0, mem_address}, 32'h0000_00C3);
        check("drain stale result", {31'd0, seen_stale}, 32'd0);
        enable   = 1'b0;
        rd_delay = 0;

        // Reset in the middle of a write.
        @(negedge clk);
        address    = 32'h0000_0210;
        write_type = RAMIO_WRITE_SW;
        read_type  = RAMIO_READ_NONE;
        data_in    = 32'h5A5A_5A5A;
        enable     = 1'b1;
        @(negedge clk);
        mem_busy = 1'b1;
        check("rstww mem_enable", {31'd0, mem_enable}, 32'd1);
        @(negedge clk);
        check("rstww busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstww mem_enable async", {31'd0, mem_enable}, 32'd0);
        check("rstww busy async", {31'd0, busy}, 32'd0);
        check("rstww strobe async", {28'd0, mem_write_strobe}, 32'd0);
        @(negedge clk);
        enable   = 1'b0;
        mem_busy = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("rstww error", {31'd0, error}, 32'd0);

        // Misaligned word read.
        mem_arr[4] = 32'h1357_9BDF;
        address    = 32'h0000_0311;
        read_type  = RAMIO_READ_LW;
        write_type = RAMIO_WRITE_NONE;
        enable     = 1'b1;
`ifdef RAMIO_ALIGN_CHECK_EN
        @(negedge clk);
        check("mis mem_enable", {31'd0, mem_enable}, 32'd0);
        check("mis busy", {31'd0, busy}, 32'd0);
        check("mis ready", {31'd0, data_out_ready}, 32'd1);
        check("mis data", data_out, 32'd0);
        check("mis error", {31'd0, error}, 32'd1);
        enable = 1'b0;
        run_vec(vecs[5], 5);
        check("mis error sticky", {31'd0, error}, 32'd1);
`else
        wait_ready(20);
        check("mis ready", {31'd0, data_out_ready}, 32'd1);
        check("mis data", data_out, 32'h1357_9BDF);
        check("mis error", {31'd0, error}, 32'd0);
        enable = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
